// File: rtl/tour_cmd_sequencer.sv
// Command queue plus handshake sequencer that feeds Knight commands to RemoteComm one at a time.
// Define KNIGHT_SEQ_RETRY_EN to resend a NAKed or timed-out command up to MAX_RETRY times before faulting.
module tour_cmd_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TMO_CYCLES = 50_000_000,
  parameter logic [7:0]  POS_ACK    = 8'hA5,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   q_wr,
  input  logic [15:0]            q_cmd,
  output logic                   q_full,
  output logic [$clog2(DEPTH):0] q_cnt,
  input  logic                   start,
  input  logic                   abort,
  output logic [15:0]            cmd,
  output logic                   snd_cmd,
  input  logic                   cmd_snt,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   err_tmo,
  output logic [7:0]             err_resp
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, FAULT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   cmd_q, cmd_d, head_data;
  logic          done_q, done_d;
  logic          err_q, err_d, err_tmo_q, err_tmo_d;
  logic [7:0]    err_resp_q, err_resp_d;
  logic          push, pop, start_ok, tmo_hit, last_entry;
  logic          nak_evt, tmo_evt, fail_evt, retry_ok;
  logic [RW-1:0] retry_cnt;

  assign q_full     = (cnt_q == CW'(DEPTH));
  assign q_cnt      = cnt_q;
  assign cmd        = cmd_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_tmo    = err_tmo_q;
  assign err_resp   = err_resp_q;

  assign push       = q_wr && !q_full;
  assign tmo_hit    = (timer_q == TMO_LAST);
  assign last_entry = (cnt_q == CW'(1)) && !push;
  assign start_ok   = (state_q == IDLE) && start && (cnt_q != '0) && !abort;
  assign fail_evt   = (nak_evt || tmo_evt) && !retry_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // resp_rdy is checked before the timer so a response on the expiry cycle still counts
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    nak_evt = 1'b0;
    tmo_evt = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (start && cnt_q != '0) state_d = SEND;
        SEND:      state_d = WAIT_SNT;
        WAIT_SNT: begin
          if (cmd_snt)      state_d = WAIT_RESP;
          else if (tmo_hit) tmo_evt = 1'b1;
        end
        WAIT_RESP: begin
          if (resp_rdy) begin
            if (resp == POS_ACK) begin
              pop     = 1'b1;
              state_d = last_entry ? IDLE : SEND;
            end else begin
              nak_evt = 1'b1;
            end
          end else if (tmo_hit) begin
            tmo_evt = 1'b1;
          end
        end
        FAULT:     state_d = IDLE;
        default:   state_d = IDLE;
      endcase
      if (nak_evt || tmo_evt) state_d = retry_ok ? SEND : FAULT;
    end
  end

  always_comb begin
    snd_cmd = (state_q == SEND) && !abort;
    busy    = (state_q != IDLE);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    // a push landing in the slot that becomes the head this cycle is not in memory yet
    head_data = (push && wr_ptr_q == rd_ptr_d) ? q_cmd : mem_q[rd_ptr_d];
    cmd_d     = (state_d == SEND) ? head_data : cmd_q;

    timer_d = '0;
    if ((state_q == WAIT_SNT || state_q == WAIT_RESP) && state_d == state_q)
      timer_d = timer_q + TW'(1);

    done_d = !abort && (((state_q == IDLE) && start && cnt_q == '0) || (pop && last_entry));

    err_d      = err_q;
    err_tmo_d  = err_tmo_q;
    err_resp_d = err_resp_q;
    if (start_ok) begin
      err_d      = 1'b0;
      err_tmo_d  = 1'b0;
      err_resp_d = 8'h00;
    end else if (fail_evt) begin
      err_d      = 1'b1;
      err_tmo_d  = tmo_evt;
      err_resp_d = tmo_evt ? 8'h00 : resp;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= q_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      cmd_q      <= 16'h0000;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_resp_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      cmd_q      <= cmd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_tmo_q  <= err_tmo_d;
      err_resp_q <= err_resp_d;
    end
  end

`ifdef KNIGHT_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;

  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (start_ok || pop)
      retry_cnt_d = '0;
    else if ((nak_evt || tmo_evt) && retry_ok)
      retry_cnt_d = retry_cnt_q + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_cnt_q <= '0;
    else        retry_cnt_q <= retry_cnt_d;
  end

  assign retry_cnt = retry_cnt_q;
`else
  // retry disabled: the count is tied off and the retry path folds away
  localparam bit RETRY_EN = 1'b0;
  assign retry_cnt = '0;
`endif

  assign retry_ok = RETRY_EN && (retry_cnt < RW'(MAX_RETRY));

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Self-checking bench for tour_cmd_sequencer: a per-cycle vector table followed by hand-written
// multi-cycle sequences (abort, reset, NAK, timeout and, when KNIGHT_SEQ_RETRY_EN is defined, retries).
module tb_tour_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;
`ifdef KNIGHT_SEQ_RETRY_EN
  localparam int TRIES = 3;
`else
  localparam int TRIES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        q_wr = 1'b0;
  logic [15:0] q_cmd = 16'h0;
  logic        q_full;
  logic [3:0]  q_cnt;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = 8'h0;
  logic        busy, done, err, err_tmo;
  logic [7:0]  err_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tour_cmd_sequencer #(
    .DEPTH(DEPTH), .TMO_CYCLES(TMO), .POS_ACK(8'hA5), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .q_wr(q_wr), .q_cmd(q_cmd), .q_full(q_full), .q_cnt(q_cnt),
    .start(start), .abort(abort), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
    .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .err(err),
    .err_tmo(err_tmo), .err_resp(err_resp)
  );

  typedef struct {
    logic        q_wr;
    logic [15:0] q_cmd;
    logic        start, abort, cmd_snt, resp_rdy;
    logic [7:0]  resp;
    logic        exp_snd;
    logic [15:0] exp_cmd;
    logic        exp_busy, exp_done, exp_err;
    logic [3:0]  exp_cnt;
    logic        exp_full;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [15:0] c, logic s, logic a, logic sn, logic rr,
                              logic [7:0] r, logic e_snd, logic [15:0] e_cmd, logic e_busy,
                              logic e_done, logic e_err, logic [3:0] e_cnt, logic e_full);
    vec_t v;
    v.q_wr = w; v.q_cmd = c; v.start = s; v.abort = a; v.cmd_snt = sn; v.resp_rdy = rr;
    v.resp = r; v.exp_snd = e_snd; v.exp_cmd = e_cmd; v.exp_busy = e_busy;
    v.exp_done = e_done; v.exp_err = e_err; v.exp_cnt = e_cnt; v.exp_full = e_full;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    q_wr = v.q_wr; q_cmd = v.q_cmd; start = v.start; abort = v.abort;
    cmd_snt = v.cmd_snt; resp_rdy = v.resp_rdy; resp = v.resp;
  endtask

  task automatic clearInputs();
    q_wr = 0; q_cmd = 0; start = 0; abort = 0; cmd_snt = 0; resp_rdy = 0; resp = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRow(input int i, input vec_t v);
    checkOutput($sformatf("row%0d_snd", i),  32'(snd_cmd), 32'(v.exp_snd));
    checkOutput($sformatf("row%0d_cmd", i),  32'(cmd),     32'(v.exp_cmd));
    checkOutput($sformatf("row%0d_busy", i), 32'(busy),    32'(v.exp_busy));
    checkOutput($sformatf("row%0d_done", i), 32'(done),    32'(v.exp_done));
    checkOutput($sformatf("row%0d_err", i),  32'(err),     32'(v.exp_err));
    checkOutput($sformatf("row%0d_tmo", i),  32'(err_tmo), 32'd0);
    checkOutput($sformatf("row%0d_cnt", i),  32'(q_cnt),   32'(v.exp_cnt));
    checkOutput($sformatf("row%0d_full", i), 32'(q_full),  32'(v.exp_full));
  endtask

  task automatic waitSnd(input string tag);
    int n;
    n = 0;
    while (!snd_cmd && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, "_snd_seen"}, 32'(snd_cmd), 32'd1);
  endtask

  // Sample point is in SEND on return from waitSnd; walk through WAIT_SNT and WAIT_RESP.
  task automatic runHandshake(input logic [7:0] r, input logic [15:0] exp_cmd, input string tag);
    waitSnd(tag);
    checkOutput({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
    step();
    cmd_snt = 1; step(); cmd_snt = 0;
    resp_rdy = 1; resp = r; step(); resp_rdy = 0; resp = 0;
  endtask

  task automatic pushCmd(input logic [15:0] c);
    q_wr = 1; q_cmd = c; step(); q_wr = 0; q_cmd = 0;
  endtask

  task automatic startRun();
    start = 1; step(); start = 0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Two-command tour, resp_rdy ignored in WAIT_SNT, start on an empty queue
    vecs.push_back(mk(1,16'h43F2,0,0,0,0,8'h00, 0,16'h0000,0,0,0,4'd1,0));
    vecs.push_back(mk(1,16'h5001,0,0,0,0,8'h00, 0,16'h0000,0,0,0,4'd2,0));
    vecs.push_back(mk(0,16'h0000,1,0,0,0,8'h00, 1,16'h43F2,1,0,0,4'd2,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,1,8'hA5, 0,16'h43F2,1,0,0,4'd2,0));
    vecs.push_back(mk(0,16'h0000,0,0,1,0,8'h00, 0,16'h43F2,1,0,0,4'd2,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,1,8'hA5, 1,16'h5001,1,0,0,4'd1,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,0,8'h00, 0,16'h5001,1,0,0,4'd1,0));
    vecs.push_back(mk(0,16'h0000,0,0,1,0,8'h00, 0,16'h5001,1,0,0,4'd1,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,1,8'hA5, 0,16'h5001,0,1,0,4'd0,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,0,8'h00, 0,16'h5001,0,0,0,4'd0,0));
    vecs.push_back(mk(0,16'h0000,1,0,0,0,8'h00, 0,16'h5001,0,1,0,4'd0,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,0,8'h00, 0,16'h5001,0,0,0,4'd0,0));
    // Fill past DEPTH: the ninth push is dropped
    for (int i = 0; i <= DEPTH; i++)
      vecs.push_back(mk(1,16'h1000 + 16'(i),0,0,0,0,8'h00, 0,16'h5001,0,0,0,
                        (i + 1 > DEPTH) ? 4'(DEPTH) : 4'(i + 1), (i + 1 >= DEPTH)));
    // Pop while full drops the push; pop with push keeps the count
    vecs.push_back(mk(0,16'h0000,1,0,0,0,8'h00, 1,16'h1000,1,0,0,4'd8,1));
    vecs.push_back(mk(0,16'h0000,0,0,0,0,8'h00, 0,16'h1000,1,0,0,4'd8,1));
    vecs.push_back(mk(0,16'h0000,0,0,1,0,8'h00, 0,16'h1000,1,0,0,4'd8,1));
    vecs.push_back(mk(1,16'h1111,0,0,0,1,8'hA5, 1,16'h1001,1,0,0,4'd7,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,0,8'h00, 0,16'h1001,1,0,0,4'd7,0));
    vecs.push_back(mk(0,16'h0000,0,0,1,0,8'h00, 0,16'h1001,1,0,0,4'd7,0));
    vecs.push_back(mk(1,16'h2222,0,0,0,1,8'hA5, 1,16'h1002,1,0,0,4'd7,0));
    // Abort in WAIT_SNT, resume at the same head, abort in WAIT_RESP beats an ack
    vecs.push_back(mk(0,16'h0000,0,0,0,0,8'h00, 0,16'h1002,1,0,0,4'd7,0));
    vecs.push_back(mk(0,16'h0000,0,1,0,0,8'h00, 0,16'h1002,0,0,0,4'd7,0));
    vecs.push_back(mk(0,16'h0000,1,0,0,0,8'h00, 1,16'h1002,1,0,0,4'd7,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,0,8'h00, 0,16'h1002,1,0,0,4'd7,0));
    vecs.push_back(mk(0,16'h0000,0,0,1,0,8'h00, 0,16'h1002,1,0,0,4'd7,0));
    vecs.push_back(mk(0,16'h0000,0,1,0,1,8'hA5, 0,16'h1002,0,0,0,4'd7,0));
    vecs.push_back(mk(0,16'h0000,0,0,0,0,8'h00, 0,16'h1002,0,0,0,4'd7,0));

    #12;
    checkOutput("rst_snd", 32'(snd_cmd), 32'd0);
    checkOutput("rst_cmd", 32'(cmd), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_cnt", 32'(q_cnt), 32'd0);
    checkOutput("rst_full", 32'(q_full), 32'd0);
    rst_n = 1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      step();
      checkRow(i, vecs[i]);
    end
    clearInputs();

    // abort while in SEND suppresses the strobe in that same cycle
    startRun();
    checkOutput("abort_send_pre", 32'(snd_cmd), 32'd1);
    abort = 1; #1;
    checkOutput("abort_send_snd", 32'(snd_cmd), 32'd0);
    step(); abort = 0;
    checkOutput("abort_send_busy", 32'(busy), 32'd0);
    checkOutput("abort_send_cnt", 32'(q_cnt), 32'd7);

    // asynchronous reset in the middle of WAIT_RESP
    startRun(); step();
    cmd_snt = 1; step(); cmd_snt = 0;
    #2; rst_n = 0; #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_cmd", 32'(cmd), 32'd0);
    checkOutput("midrst_cnt", 32'(q_cnt), 32'd0);
    checkOutput("midrst_err", {29'd0, err, err_tmo, done}, 32'd0);
    checkOutput("midrst_resp", 32'(err_resp), 32'd0);
    @(negedge clk); rst_n = 1; step();
    checkOutput("postrst_cnt", 32'(q_cnt), 32'd0);

    // NAK leads to a fault with the head retained, then a restart drains it
    pushCmd(16'h2000);
    startRun();
    for (int t = 0; t < TRIES; t++) runHandshake(8'h5A, 16'h2000, "nak");
    checkOutput("nak_err", 32'(err), 32'd1);
    checkOutput("nak_tmo", 32'(err_tmo), 32'd0);
    checkOutput("nak_resp", 32'(err_resp), 32'h5A);
    checkOutput("nak_cnt", 32'(q_cnt), 32'd1);
    step();
    checkOutput("nak_idle_busy", 32'(busy), 32'd0);
    checkOutput("nak_sticky_err", 32'(err), 32'd1);
    startRun();
    checkOutput("nak_restart_err", 32'(err), 32'd0);
    checkOutput("nak_restart_resp", 32'(err_resp), 32'd0);
    runHandshake(8'hA5, 16'h2000, "nak_resume");
    checkOutput("nak_resume_done", 32'(done), 32'd1);
    checkOutput("nak_resume_cnt", 32'(q_cnt), 32'd0);

    // response timeout: fault exactly TMO cycles after entering WAIT_RESP
    pushCmd(16'h3000);
    startRun();
    for (int t = 0; t < TRIES; t++) begin
      waitSnd("tmo");
      checkOutput("tmo_cmd", 32'(cmd), 32'h3000);
      step();
      cmd_snt = 1; step(); cmd_snt = 0;
      repeat (TMO - 1) step();
      checkOutput("tmo_early_err", 32'(err), 32'd0);
      checkOutput("tmo_early_busy", 32'(busy), 32'd1);
      step();
      if (t == TRIES - 1) begin
        checkOutput("tmo_err", 32'(err), 32'd1);
        checkOutput("tmo_flag", 32'(err_tmo), 32'd1);
        checkOutput("tmo_resp", 32'(err_resp), 32'd0);
        checkOutput("tmo_cnt", 32'(q_cnt), 32'd1);
      end else begin
        checkOutput("tmo_retry_snd", 32'(snd_cmd), 32'd1);
      end
    end
    step(); step();
    checkOutput("tmo_idle_busy", 32'(busy), 32'd0);
    checkOutput("tmo_sticky", 32'(err_tmo), 32'd1);
    startRun();
    checkOutput("tmo_restart_flag", 32'(err_tmo), 32'd0);
    runHandshake(8'hA5, 16'h3000, "tmo_resume");
    checkOutput("tmo_resume_done", 32'(done), 32'd1);

`ifdef KNIGHT_SEQ_RETRY_EN
    // two NAKs then an ack on one command, then the count restarts for the next command
    pushCmd(16'h4000);
    pushCmd(16'h4001);
    startRun();
    runHandshake(8'h5A, 16'h4000, "rty1");
    runHandshake(8'h5A, 16'h4000, "rty2");
    checkOutput("rty_err_mid", 32'(err), 32'd0);
    runHandshake(8'hA5, 16'h4000, "rty3");
    checkOutput("rty_cnt", 32'(q_cnt), 32'd1);
    runHandshake(8'h5A, 16'h4001, "rty4");
    checkOutput("rty_pop_clears_snd", 32'(snd_cmd), 32'd1);
    checkOutput("rty_pop_clears_err", 32'(err), 32'd0);
    runHandshake(8'hA5, 16'h4001, "rty5");
    checkOutput("rty_done", 32'(done), 32'd1);
    checkOutput("rty_final_err", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
